// File: rtl/tt_um_ha_pkg.sv
// ---------------------------------------------------------------------------
// tt_um_ha_pkg
// Shared constants for the half-adder bank tile.
//   NUM_HA        : number of half-adder cells (fixed by the pin map)
//   OPA_LSB/OPB_LSB : bit offsets of operands A and B inside ui_in
//   HOLD_BIT/CLR_BIT: bit offsets of hold and clear inside uio_in
//   UIO_OE_VALUE  : constant bidirectional output-enable pattern
// Also provides f_popcount, a count-ones helper for the carry vector.
// ---------------------------------------------------------------------------
package tt_um_ha_pkg;

    localparam int NUM_HA   = 4;
    localparam int OPA_LSB  = 0;
    localparam int OPB_LSB  = 4;
    localparam int HOLD_BIT = 0;
    localparam int CLR_BIT  = 1;

    localparam logic [7:0] UIO_OE_VALUE = 8'hF0;

    // Number of ones in a NUM_HA-bit vector; 3 bits covers 0..4.
    function automatic logic [2:0] f_popcount(input logic [NUM_HA-1:0] i_v);
        logic [2:0] w_cnt;
        w_cnt = 3'd0;
        for (int i = 0; i < NUM_HA; i++) begin
            w_cnt = w_cnt + {2'b00, i_v[i]};
        end
        return w_cnt;
    endfunction

endpackage

// File: rtl/tt_um_ha_cell.sv
// ---------------------------------------------------------------------------
// ha_cell
// Purely combinational 1-bit half adder.
//   a, b : operand bits
//   s    : sum   = a ^ b
//   c    : carry = a & b
// ---------------------------------------------------------------------------
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/tt_um_ha.sv
// ---------------------------------------------------------------------------
// tt_um_ha
// Tiny Tapeout tile: four independent registered 1-bit half adders.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   ena     : tile enable from the harness
//   ui_in   : [3:0] operand A, [7:4] operand B
//   uo_out  : [3:0] registered sum, [7:4] registered carry
//   uio_in  : [0] hold, [1] synchronous clear, [7:2] ignored
//   uio_out : [3:0] zero, [6:4] carry popcount, [7] sum parity
//   uio_oe  : constant 8'hF0
// All outputs come straight from registers; there is no combinational path
// from ui_in to any output.
// ---------------------------------------------------------------------------
module tt_um_ha
    import tt_um_ha_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [NUM_HA-1:0] w_a;
    logic [NUM_HA-1:0] w_b;
    logic [NUM_HA-1:0] w_s;
    logic [NUM_HA-1:0] w_c;
    logic [2:0]        w_pc;
    logic              w_par;
    logic              w_hold;
    logic              w_clr;
    logic              w_unused;

    logic [NUM_HA-1:0] r_s;
    logic [NUM_HA-1:0] r_c;
    logic [2:0]        r_pc;
    logic              r_par;

    assign w_a    = ui_in[OPA_LSB +: NUM_HA];
    assign w_b    = ui_in[OPB_LSB +: NUM_HA];
    assign w_hold = uio_in[HOLD_BIT];
    assign w_clr  = uio_in[CLR_BIT];

    // uio_in[7:2] carry no function in this tile.
    assign w_unused = &{1'b0, uio_in[7:2]};

    for (genvar g = 0; g < NUM_HA; g++) begin : g_cell
        ha_cell u_cell (
            .a (w_a[g]),
            .b (w_b[g]),
            .s (w_s[g]),
            .c (w_c[g])
        );
    end

    assign w_pc  = f_popcount(w_c);
    assign w_par = ^w_s;

    // Priority: async reset, then clear (beats hold), then enabled load,
    // otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s   <= '0;
            r_c   <= '0;
            r_pc  <= '0;
            r_par <= 1'b0;
        end else if (w_clr) begin
            r_s   <= '0;
            r_c   <= '0;
            r_pc  <= '0;
            r_par <= 1'b0;
        end else if (ena && !w_hold) begin
            r_s   <= w_s;
            r_c   <= w_c;
            r_pc  <= w_pc;
            r_par <= w_par;
        end
    end

    assign uo_out  = {r_c, r_s};
    assign uio_out = {r_par, r_pc, 4'b0000};
    assign uio_oe  = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_ha.sv
// ---------------------------------------------------------------------------
// tb_tt_um_ha
// Directed plus exhaustive stimulus for the half-adder bank tile. Expected
// output words {uio_out, uo_out} are pushed to exp_q when a step is driven and
// popped for comparison one edge later.
// ---------------------------------------------------------------------------
module tb_tt_um_ha;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [15:0] exp_q[$];
    logic [15:0] model;
    int          checks;
    int          errors;

    tt_um_ha dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Clock: 10 time-unit period, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {par, pc, 4'b0, carry, sum} for one operand byte.
    function automatic logic [15:0] ref_word(input logic [7:0] ui);
        logic [3:0] a, b, s, c;
        logic [2:0] pc;
        a  = ui[3:0];
        b  = ui[7:4];
        s  = a ^ b;
        c  = a & b;
        pc = 3'd0;
        for (int i = 0; i < 4; i++) pc = pc + {2'b00, c[i]};
        return {^s, pc, 4'b0000, c, s};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_oe(input string tag);
        check(tag, {8'h00, uio_oe}, 16'h00F0);
    endtask

    // Drive one cycle of inputs, predict the registered result, then compare
    // one time unit after the rising edge.
    task automatic step(input string tag, input logic [7:0] ui,
                        input logic [7:0] uio, input logic en);
        logic [15:0] e;
        ui_in  = ui;
        uio_in = uio;
        ena    = en;
        if (uio[1])              model = 16'h0000;
        else if (en && !uio[0])  model = ref_word(ui);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 16'hFFFF, 16'h0000);
        end else begin
            e = exp_q.pop_front();
            check(tag, {uio_out, uo_out}, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model  = 16'h0000;

        // Reset with operands all ones, before any clock edge.
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'hFF;
        #2;
        check("reset_out", {uio_out, uo_out}, 16'h0000);
        check_oe("reset_oe");
        @(posedge clk);
        #1;
        check("reset_held", {uio_out, uo_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Basic add: no change before the edge, result after it.
        ui_in = 8'h35;
        #1;
        check("pre_edge", {uio_out, uo_out}, 16'h0000);
        step("add_35", 8'h35, 8'h00, 1'b1);
        check("add_35_const", {uio_out, uo_out}, 16'h1016);
        check_oe("oe_run");

        step("add_ff", 8'hFF, 8'h00, 1'b1);
        check("add_ff_const", {uio_out, uo_out}, 16'h40F0);
        step("add_0f", 8'h0F, 8'h00, 1'b1);
        check("add_0f_const", {uio_out, uo_out}, 16'h000F);
        step("add_01", 8'h01, 8'h00, 1'b1);
        check("add_01_const", {uio_out, uo_out}, 16'h8001);

        // Hold via uio_in[0].
        step("load_35", 8'h35, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step("hold_bit", 8'hFF, 8'h01, 1'b1);
        check("hold_bit_const", {uio_out, uo_out}, 16'h1016);

        // Hold via ena low.
        for (int i = 0; i < 3; i++) step("hold_ena", 8'hFF, 8'h00, 1'b0);
        check("hold_ena_const", {uio_out, uo_out}, 16'h1016);

        // Clear beats hold.
        step("clear_hold", 8'hFF, 8'h03, 1'b1);
        check("clear_const", {uio_out, uo_out}, 16'h0000);
        step("reload_ff", 8'hFF, 8'h00, 1'b1);
        step("clear_no_ena", 8'hFF, 8'h02, 1'b0);

        // Exhaustive sweep with random junk on the ignored uio_in bits.
        for (int v = 0; v < 256; v++) begin
            logic [5:0] junk;
            junk = 6'($urandom_range(0, 63));
            if (v == 128) begin
                // Asynchronous reset pulse between edges.
                #2;
                rst_n = 1'b0;
                #1;
                check("async_rst", {uio_out, uo_out}, 16'h0000);
                check_oe("async_oe");
                #1;
                rst_n = 1'b1;
                model = 16'h0000;
                #1;
                check("async_release", {uio_out, uo_out}, 16'h0000);
            end
            step("sweep", 8'(v), {junk, 2'b00}, 1'b1);
        end
        check("last_sweep", {uio_out, uo_out}, 16'h40F0);

        if (exp_q.size() != 0) check("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_ha.md
Name: tt_um_ha

Overview:
- Tiny Tapeout user tile implementing a bank of four independent registered 1-bit half adders.
- The dedicated input byte supplies two 4-bit operands. The dedicated output byte returns per-bit sum and carry.
- The upper bidirectional pins return summary flags (carry count, sum parity).
- Sits directly under the Tiny Tapeout harness; no other logic in the tile.

Parameters:
- NUM_HA, 4, number of half-adder cells. Fixed at 4 by the pin map; not user-overridable in this tile.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  tile enable from harness; high when the design is selected.
- ui_in  input  8  [3:0] operand A, [7:4] operand B.
- uo_out  output  8  [3:0] registered sum S, [7:4] registered carry C.
- uio_in  input  8  [0] hold, [1] synchronous clear, [7:2] unused/ignored.
- uio_out  output  8  [3:0] driven 0, [6:4] carry popcount, [7] sum parity.
- uio_oe  output  8  constant 8'hF0: upper nibble output, lower nibble input.

Behaviour:
- Per cell i (0..3): s[i] = A[i] XOR B[i]; c[i] = A[i] AND B[i]. No carry propagation between cells.
- Flags:
  - pc = number of ones in c (0..4, 3 bits).
  - par = XOR-reduce of s.
- Registers: S_q[3:0], C_q[3:0], PC_q[2:0], PAR_q. uo_out = {C_q, S_q}. uio_out = {PAR_q, PC_q, 4'b0000}.
- Latency: operands sampled on a rising clk edge appear on the outputs immediately after that edge (1-cycle latency). No combinational path from ui_in to any output.
- Update priority at each rising edge, highest first:
  - rst_n low (asynchronous, takes effect without clk): all registers 0.
  - uio_in[1] = 1: all registers 0 (synchronous clear).
  - ena = 1 and uio_in[0] = 0: load newly computed s, c, pc, par.
  - otherwise: hold previous values.
- Reset values: uo_out = 8'h00, uio_out = 8'h00. uio_oe = 8'hF0 at all times, including during reset.
- Reset deasserted mid-operation: first load occurs at the first rising edge with rst_n high and load conditions met.
- Clear and hold asserted together: clear wins.
- Unused inputs (uio_in[7:2]) have no effect. uio_out[3:0] is permanently 0.

Decomposition:
- Shared package tt_um_ha_pkg holds:
  - NUM_HA = 4.
  - Field offsets: OPA_LSB = 0, OPB_LSB = 4, HOLD_BIT = 0, CLR_BIT = 1.
  - UIO_OE_VALUE = 8'hF0.
- One sub-module ha_cell: inputs a and b, outputs s and c, purely combinational. Instantiated NUM_HA times.
- Popcount, parity and the registers live in the top.

Test Plan:
- Reset: rst_n = 0 with ui_in = 8'hFF, no clock edge -> uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'hF0 immediately.
- Basic add: ena = 1, uio_in = 0, ui_in = 8'h35 (A = 0101, B = 0011), one edge -> uo_out = 8'h16, uio_out = 8'h10 (pc = 1, par = 0). Outputs unchanged before the edge.
- All-ones and one-sided operands:
  - ui_in = 8'hFF -> uo_out = 8'hF0, uio_out = 8'h40.
  - ui_in = 8'h0F -> uo_out = 8'h0F, uio_out = 8'h00.
  - ui_in = 8'h01 -> uo_out = 8'h01, uio_out = 8'h80.
- Hold and enable: load 8'h35, then set uio_in[0] = 1 and apply ui_in = 8'hFF for 3 cycles -> outputs stay 8'h16/8'h10. Repeat with ena = 0 and hold = 0 -> same hold result.
- Clear priority: outputs nonzero, then uio_in = 8'h03 (clear and hold) for one edge -> uo_out = 8'h00, uio_out = 8'h00.
- Exhaustive: all 256 ui_in values with ena = 1, each checked one cycle later against the per-bit XOR/AND, popcount and parity model. Include an async rst_n pulse between edges mid-sweep -> outputs drop to 0 at once and resume on the next edge after release.
